// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Iteration counter must hold 0..WIDTH inclusive.
   function automatic int cnt_width(input int w);
      return (w < 1) ? 1 : $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus for seq_divider.
// div_zero is present only when DIVZERO_DETECT_EN is defined.
interface seq_divider_if
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIVZERO_DETECT_EN
   logic             div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder
   );
`endif

endinterface

// File: rtl/seq_divider_addsub_stage.sv
// Parameterised ripple-carry adder/subtractor built from full-adder cells.
// m=1 subtracts (b inverted, carry-in 1); cout=1 then means no borrow.
module addsub_stage #(
   parameter int W = 5
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         m,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0]   c;
   logic [W-1:0] bx;

   assign bx   = b ^ {W{m}};
   assign c[0] = m;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
   end

   assign cout = c[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIVZERO_DETECT_EN: zero divisor short-cuts to DONE and raises div_zero.
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_shift;
   logic             cout;
   logic             accept;
   logic             last_iter;
   logic             dz_start;
   logic             unused_rem_msb;

   assign r_shift        = {rem_r[WIDTH-1:0], quo_sh[WIDTH-1]};
   assign q_shift        = quo_sh << 1;
   assign last_iter      = (cnt == CW'(WIDTH - 1));
   // Restore never leaves R >= D, so the top bit of R stays zero.
   assign unused_rem_msb = rem_r[WIDTH];

`ifdef DIVZERO_DETECT_EN
   logic dz_r;
   assign dz_start = (bus.divisor == '0);
`else
   assign dz_start = 1'b0;
`endif

   addsub_stage #(.W(WIDTH + 1)) u_sub (
      .a    (r_shift),
      .b    ({1'b0, div_r}),
      .m    (1'b1),
      .s    (trial),
      .cout (cout)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = dz_start ? DONE : CALC;
            end
         end
         CALC:    if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= '0;
         else if (state == CALC)
            cnt <= cnt + 1'b1;
      end
   end

   // Working registers carry no reset: they are always loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         div_r <= bus.divisor;
         if (dz_start) begin
            quo_sh <= '1;
            rem_r  <= {1'b0, bus.dividend};
         end else begin
            quo_sh <= bus.dividend;
            rem_r  <= '0;
         end
      end else if (state == CALC) begin
         quo_sh <= q_shift | WIDTH'(cout);
         rem_r  <= cout ? trial : r_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
      end else begin
         bus.done <= (state == DONE);
         if (accept)
            bus.busy <= 1'b1;
         else if (state == DONE)
            bus.busy <= 1'b0;
         if (state == DONE) begin
            bus.quotient  <= quo_sh;
            bus.remainder <= rem_r[WIDTH-1:0];
         end
      end
   end

`ifdef DIVZERO_DETECT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dz_r         <= 1'b0;
         bus.div_zero <= 1'b0;
      end else if (accept) begin
         dz_r         <= dz_start;
         bus.div_zero <= 1'b0;
      end else if (state == DONE) begin
         bus.div_zero <= dz_r;
      end
   end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expectations, a monitor checks each done pulse.
module tb_seq_divider;
   import seq_div_pkg::*;

   localparam int WIDTH = 4;
`ifdef DIVZERO_DETECT_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif

   typedef struct {
      int q;
      int r;
      int dz;
      int done_cyc;
      int busy_len;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Called just after a negedge; returns at the negedge following the accept edge.
   task automatic issue(input int dd, input int dv, input bit push,
                        input int q, input int r, input int dz);
      exp_t e;
      int   lat;
      bus.dividend = dd[WIDTH-1:0];
      bus.divisor  = dv[WIDTH-1:0];
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      if (push) begin
         lat        = (DZ && dz != 0) ? 1 : WIDTH + 1;
         e.q        = q;
         e.r        = r;
         e.dz       = DZ ? dz : 0;
         e.done_cyc = cyc + lat;
         e.busy_len = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) return;
      end
      check("done_timeout", bus.done, 1);
   endtask

   initial begin : monitor
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run = 0;
         end else if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("quotient", bus.quotient, e.q);
               check("remainder", bus.remainder, e.r);
               check("done_latency", cyc, e.done_cyc);
               check("busy_cycles", run, e.busy_len);
`ifdef DIVZERO_DETECT_EN
               check("div_zero", bus.div_zero, e.dz);
`endif
            end
            run = 0;
         end else if (bus.busy) begin
            run++;
         end
      end
   end

   initial begin : stim
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
`ifdef DIVZERO_DETECT_EN
      check("rst_div_zero", bus.div_zero, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // 7 / 2 = 3 r 1
      issue(7, 2, 1'b1, 3, 1, 0);
      wait_done();

      // 15 / 1, then 3 / 4 started in the cycle after the first done
      issue(15, 1, 1'b1, 15, 0, 0);
      wait_done();
      @(negedge clk);
      issue(3, 4, 1'b1, 0, 3, 0);
      wait_done();

      // 0 / 5 with a stray 12 / 3 start during busy that must be ignored
      @(negedge clk);
      issue(0, 5, 1'b1, 0, 0, 0);
      @(negedge clk);
      bus.dividend = 4'd12;
      bus.divisor  = 4'd3;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();

      // 9 / 0 gives all-ones quotient and the dividend as remainder
      @(negedge clk);
      issue(9, 0, 1'b1, 15, 9, 1);
      wait_done();

      // Reset during CALC abandons the operation with no done pulse
      @(negedge clk);
      issue(7, 2, 1'b0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_quotient", bus.quotient, 0);
      check("midrst_remainder", bus.remainder, 0);
`ifdef DIVZERO_DETECT_EN
      check("midrst_div_zero", bus.div_zero, 0);
`endif
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_done", bus.done, 0);

      // Sweep every pair with a nonzero divisor
      for (int dd = 0; dd < (1 << WIDTH); dd++) begin
         for (int dv = 1; dv < (1 << WIDTH); dv++) begin
            issue(dd, dv, 1'b1, dd / dv, dd % dv, 0);
            wait_done();
            @(negedge clk);
         end
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
